// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART parity/state types and frame-length helper
// Contents:
//   parity_t     parity mode, shared by receiver and transmitter
//   rx_state_t   receiver FSM states
//   frame_bits   total bits on the line per frame (start + data + parity + stop)
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_EVEN = 2'd1,
      PARITY_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK_WAIT
   } rx_state_t;

   function automatic int frame_bits(input int data_bits, input int stop_bits, input parity_t parity);
      return 1 + data_bits + ((parity == PARITY_NONE) ? 0 : 1) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// rtl/uart_bit_sampler.sv - line synchroniser, bit-period counter and 3-sample majority vote
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   data_in      asynchronous serial line (idle high)
//   restart      forces the bit counter to 0 on the next clock
//   rx_s         synchronised line, two clocks behind data_in
//   bit_strobe   high for one clock at the decision point (cnt == MID+1)
//   bit_value    majority of the samples at MID-1, MID and MID+1
//   cnt_wrap     high on the last count of a bit period
module uart_bit_sampler #(
   parameter int CLKS_PER_BIT = 1250
) (
   input  logic clk,
   input  logic reset,
   input  logic data_in,
   input  logic restart,
   output logic rx_s,
   output logic bit_strobe,
   output logic bit_value,
   output logic cnt_wrap
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int MID   = CLKS_PER_BIT / 2;

   logic             sync1;
   logic [CNT_W-1:0] cnt;
   logic             samp_a;
   logic             samp_b;

   // Sync flops reset to 1 so an idle line never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b1;
         rx_s   <= 1'b1;
         cnt    <= '0;
         samp_a <= 1'b1;
         samp_b <= 1'b1;
      end else begin
         sync1 <= data_in;
         rx_s  <= sync1;
         if (restart || cnt_wrap)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         if (cnt == CNT_W'(MID - 1))
            samp_a <= rx_s;
         if (cnt == CNT_W'(MID))
            samp_b <= rx_s;
      end
   end

   assign cnt_wrap   = (cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign bit_strobe = (cnt == CNT_W'(MID + 1));
   // Third sample is the live rx_s at the decision clock.
   assign bit_value  = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receiver with error flags and valid/ready output
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   data_in         asynchronous serial line, idle high, LSB first
//   data_out        received word, held while valid && !ready
//   valid / ready   output handshake; word accepted on valid && ready
//   parity_error    parity mismatch of presented word (qualified by valid)
//   framing_error   a stop bit sampled 0 (qualified by valid)
//   overrun         frames dropped while this word stalled (qualified by valid)
//   busy            receiver is inside a frame or waiting out a break
module uart_rx_oversampled
   import uart_pkg::*;
#(
   parameter int      DATA_BITS    = 8,
   parameter int      STOP_BITS    = 1,
   parameter parity_t PARITY       = PARITY_NONE,
   parameter int      CLKS_PER_BIT = 1250
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 data_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   input  logic                 ready,
   output logic                 parity_error,
   output logic                 framing_error,
   output logic                 overrun,
   output logic                 busy
);
   localparam int IDX_W = $clog2(frame_bits(DATA_BITS, STOP_BITS, PARITY));

   rx_state_t            state;
   rx_state_t            state_next;
   logic                 rx_s;
   logic                 bit_strobe;
   logic                 bit_value;
   logic                 cnt_wrap;
   logic                 restart;
   logic                 complete;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_err;
   logic                 frm_acc;
   logic                 par_now;
   logic                 frm_now;

   uart_bit_sampler #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_sampler (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .restart    (restart),
      .rx_s       (rx_s),
      .bit_strobe (bit_strobe),
      .bit_value  (bit_value),
      .cnt_wrap   (cnt_wrap)
   );

   // Parity error when the XOR of data and parity bit disagrees with the mode.
   assign par_now = (PARITY == PARITY_ODD) ? ~((^shreg) ^ bit_value) : ((^shreg) ^ bit_value);
   assign frm_now = frm_acc | ~bit_value;

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      restart    = 1'b0;
      complete   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rx_s) begin
               state_next = ST_START;
               restart    = 1'b1;
            end
         end
         ST_START: begin
            // The decision precedes the wrap, so reaching the wrap means a real start bit.
            if (bit_strobe && bit_value)
               state_next = ST_IDLE;
            else if (cnt_wrap)
               state_next = ST_DATA;
         end
         ST_DATA: begin
            if (bit_strobe && bit_idx == IDX_W'(DATA_BITS - 1))
               state_next = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
         end
         ST_PARITY: begin
            if (bit_strobe)
               state_next = ST_STOP;
         end
         ST_STOP: begin
            // Leave mid-bit so the next start edge is caught early.
            if (bit_strobe && bit_idx == IDX_W'(STOP_BITS - 1)) begin
               complete   = 1'b1;
               state_next = bit_value ? ST_IDLE : ST_BREAK_WAIT;
            end
         end
         ST_BREAK_WAIT: begin
            if (rx_s)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_idx       <= '0;
         shreg         <= '0;
         par_err       <= 1'b0;
         frm_acc       <= 1'b0;
         data_out      <= '0;
         valid         <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         if (state_next != state)
            bit_idx <= '0;
         else if (bit_strobe)
            bit_idx <= bit_idx + 1'b1;

         if (restart) begin
            par_err <= 1'b0;
            frm_acc <= 1'b0;
         end

         if (bit_strobe) begin
            case (state)
               ST_DATA:   shreg   <= {bit_value, shreg[DATA_BITS-1:1]};
               ST_PARITY: par_err <= par_now;
               ST_STOP:   frm_acc <= frm_now;
               default:   ;
            endcase
         end

         if (complete) begin
            if (!valid || ready) begin
               data_out      <= shreg;
               parity_error  <= par_err;
               framing_error <= frm_now;
               overrun       <= 1'b0;
               valid         <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid         <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
         end
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - self-checking bench for uart_rx_oversampled
// Three receivers (no parity / even parity with 2 stop bits / odd parity) share clock,
// reset and ready; each has its own serial line.
module tb_uart_rx_oversampled;

   localparam int CPB = 16;

   typedef struct {
      int         dut;
      int         due;
      logic [7:0] data;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ready = 1'b1;
   logic [2:0] line = 3'b111;
   logic [7:0] dout [3];
   logic       valid_o [3];
   logic       pe_o [3];
   logic       fe_o [3];
   logic       ovr_o [3];
   logic       busy_o [3];

   int p_par [3]  = '{0, 1, 2};
   int p_stop [3] = '{1, 2, 1};

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic chk_en = 1'b0;
   exp_t expq [$];

   bit       m_valid [3];
   bit [7:0] m_data [3];
   bit       m_pe [3];
   bit       m_fe [3];
   bit       m_ovr [3];
   logic     rst_prev = 1'b1;
   logic     rdy_prev = 1'b1;

   logic       vprev [3] = '{1'b0, 1'b0, 1'b0};
   int         rises [3] = '{0, 0, 0};
   int         last_rise [3] = '{0, 0, 0};
   logic [7:0] last_data [3];
   logic       last_pe [3];
   logic       last_fe [3];
   logic       last_ovr [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_oversampled #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(uart_pkg::PARITY_NONE), .CLKS_PER_BIT(CPB)) dut_n (
      .clk(clk), .reset(reset), .data_in(line[0]), .data_out(dout[0]), .valid(valid_o[0]), .ready(ready),
      .parity_error(pe_o[0]), .framing_error(fe_o[0]), .overrun(ovr_o[0]), .busy(busy_o[0]));

   uart_rx_oversampled #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(uart_pkg::PARITY_EVEN), .CLKS_PER_BIT(CPB)) dut_e (
      .clk(clk), .reset(reset), .data_in(line[1]), .data_out(dout[1]), .valid(valid_o[1]), .ready(ready),
      .parity_error(pe_o[1]), .framing_error(fe_o[1]), .overrun(ovr_o[1]), .busy(busy_o[1]));

   uart_rx_oversampled #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(uart_pkg::PARITY_ODD), .CLKS_PER_BIT(CPB)) dut_o (
      .clk(clk), .reset(reset), .data_in(line[2]), .data_out(dout[2]), .valid(valid_o[2]), .ready(ready),
      .parity_error(pe_o[2]), .framing_error(fe_o[2]), .overrun(ovr_o[2]), .busy(busy_o[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic push_exp(input int d, input int due, input logic [7:0] data, input logic pe, input logic fe);
      exp_t e;
      e.dut = d; e.due = due; e.data = data; e.pe = pe; e.fe = fe;
      expq.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // A frame starting at edge k0 has its final-stop decision sample of the line
   // at k0 + CPB*(nb-1) + 10; valid is then seen 3 clocks later.
   task automatic send_frame(input int d, input logic [7:0] data, input logic par_bad,
                             input logic stop_bad, input int gb, input int go, output int k0);
      logic bits [$];
      logic pb;
      int   nb;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(data[i]);
      if (p_par[d] != 0) begin
         pb = ^data;
         if (p_par[d] == 2) pb = ~pb;
         bits.push_back(pb ^ par_bad);
      end
      for (int i = 0; i < p_stop[d]; i++) bits.push_back(~stop_bad);
      nb = bits.size();
      @(posedge clk);
      #1;
      k0 = cyc;
      push_exp(d, k0 + CPB * (nb - 1) + 13, data, par_bad && (p_par[d] != 0), stop_bad);
      for (int b = 0; b < nb; b++) begin
         for (int j = 0; j < CPB; j++) begin
            line[d] = bits[b] ^ ((b == gb) && (j == go));
            @(posedge clk);
            #1;
         end
      end
      line[d] = 1'b1;
   endtask

   // Frame-level reference: expected frames complete at their due cycle, then the
   // handshake rules decide what the output register presents.
   always @(negedge clk) begin
      exp_t e;
      logic [2:0] comp;
      comp = 3'b000;
      if (rst_prev) begin
         for (int d = 0; d < 3; d++) begin
            m_valid[d] = 0; m_data[d] = 0; m_pe[d] = 0; m_fe[d] = 0; m_ovr[d] = 0;
         end
         expq.delete();
      end else begin
         if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            comp[e.dut] = 1'b1;
         end
         for (int d = 0; d < 3; d++) begin
            if (comp[d]) begin
               if (!m_valid[d] || rdy_prev) begin
                  m_valid[d] = 1; m_data[d] = e.data; m_pe[d] = e.pe; m_fe[d] = e.fe; m_ovr[d] = 0;
               end else begin
                  m_ovr[d] = 1;
               end
            end else if (m_valid[d] && rdy_prev) begin
               m_valid[d] = 0; m_pe[d] = 0; m_fe[d] = 0; m_ovr[d] = 0;
            end
         end
      end
      if (chk_en) begin
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (valid_o[d] !== m_valid[d]) begin
               errors++;
               $display("FAIL valid[%0d] @cyc %0d: got %b expected %b", d, cyc, valid_o[d], m_valid[d]);
            end
            if (m_valid[d]) begin
               checks++;
               if (dout[d] !== m_data[d] || pe_o[d] !== m_pe[d] || fe_o[d] !== m_fe[d] || ovr_o[d] !== m_ovr[d]) begin
                  errors++;
                  $display("FAIL word[%0d] @cyc %0d: got data=%h pe=%b fe=%b ovr=%b expected data=%h pe=%b fe=%b ovr=%b",
                           d, cyc, dout[d], pe_o[d], fe_o[d], ovr_o[d], m_data[d], m_pe[d], m_fe[d], m_ovr[d]);
               end
            end
            if (valid_o[d] === 1'b1 && vprev[d] !== 1'b1) begin
               rises[d]++;
               last_rise[d] = cyc;
               last_data[d] = dout[d];
               last_pe[d] = pe_o[d];
               last_fe[d] = fe_o[d];
               last_ovr[d] = ovr_o[d];
            end
            vprev[d] = valid_o[d];
         end
      end
      rst_prev = reset;
      rdy_prev = ready;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  k0;
      int  r;
      bit  rand_done;
      rand_done = 0;

      idle(3);
      reset = 1'b0;
      idle(2);
      chk_en = 1'b1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset_valid[%0d]", d), valid_o[d], 0);
         chk($sformatf("reset_busy[%0d]", d), busy_o[d], 0);
         chk($sformatf("reset_data[%0d]", d), dout[d], 0);
         chk($sformatf("reset_flags[%0d]", d), {pe_o[d], fe_o[d], ovr_o[d]}, 0);
      end

      // Clean 0xA5, no parity
      r = rises[0];
      send_frame(0, 8'hA5, 0, 0, -1, 0, k0);
      idle(4);
      chk("a5_rises", rises[0], r + 1);
      chk("a5_data", last_data[0], 8'hA5);
      chk("a5_flags", {last_pe[0], last_fe[0], last_ovr[0]}, 0);
      chk("a5_latency", last_rise[0], k0 + 157);
      chk("a5_busy_done", busy_o[0], 0);

      // Even parity (2 stop bits): 0x03 with parity bit 0, then bit 1
      send_frame(1, 8'h03, 0, 0, -1, 0, k0);
      idle(4);
      chk("even_ok_pe", last_pe[1], 0);
      chk("even_ok_latency", last_rise[1], k0 + 189);
      send_frame(1, 8'h03, 1, 0, -1, 0, k0);
      idle(4);
      chk("even_bad_data", last_data[1], 8'h03);
      chk("even_bad_pe", last_pe[1], 1);

      // Odd parity: 0x03 with parity bit 1 is correct, bit 0 is an error
      send_frame(2, 8'h03, 0, 0, -1, 0, k0);
      idle(4);
      chk("odd_ok_pe", last_pe[2], 0);
      send_frame(2, 8'h03, 1, 0, -1, 0, k0);
      idle(4);
      chk("odd_bad_pe", last_pe[2], 1);

      // Stop bit low on 0x5A
      send_frame(0, 8'h5A, 0, 1, -1, 0, k0);
      idle(6);
      chk("stop0_data", last_data[0], 8'h5A);
      chk("stop0_fe", last_fe[0], 1);

      // Line held low for three frame times
      r = rises[0];
      @(posedge clk);
      #1;
      k0 = cyc;
      push_exp(0, k0 + 157, 8'h00, 0, 1);
      line[0] = 1'b0;
      idle(480);
      chk("break_busy", busy_o[0], 1);
      chk("break_one_word", rises[0], r + 1);
      line[0] = 1'b1;
      idle(4);
      chk("break_release_busy", busy_o[0], 0);
      chk("break_data", last_data[0], 8'h00);
      chk("break_fe", last_fe[0], 1);
      idle(4);
      send_frame(0, 8'h33, 0, 0, -1, 0, k0);
      idle(4);
      chk("after_break_data", last_data[0], 8'h33);
      chk("after_break_fe", last_fe[0], 0);

      // 3-clk start pulse is a false start
      r = rises[0];
      @(posedge clk);
      #1;
      k0 = cyc;
      line[0] = 1'b0;
      idle(3);
      line[0] = 1'b1;
      idle(2);
      chk("false_start_busy", busy_o[0], 1);
      idle(8);
      chk("false_start_idle", busy_o[0], 0);
      idle(200);
      chk("false_start_no_word", rises[0], r);

      // Glitch on the MID sample of data bit 2
      send_frame(0, 8'hFF, 0, 0, 3, 9, k0);
      idle(4);
      chk("glitch_data", last_data[0], 8'hFF);

      // Overrun while stalled
      ready = 1'b0;
      send_frame(0, 8'h11, 0, 0, -1, 0, k0);
      idle(5);
      send_frame(0, 8'h22, 0, 0, -1, 0, k0);
      idle(2);
      chk("ovr_valid", valid_o[0], 1);
      chk("ovr_data", dout[0], 8'h11);
      chk("ovr_flag", ovr_o[0], 1);
      ready = 1'b1;
      idle(1);
      chk("ovr_accept", valid_o[0], 0);
      send_frame(0, 8'h44, 0, 0, -1, 0, k0);
      idle(4);
      chk("ovr_next_data", last_data[0], 8'h44);
      chk("ovr_next_flag", last_ovr[0], 0);

      // Reset mid-DATA discards the frame and the pending word
      ready = 1'b0;
      send_frame(0, 8'h66, 0, 0, -1, 0, k0);
      idle(6);
      chk("pre_reset_valid", valid_o[0], 1);
      line[0] = 1'b0;
      idle(CPB * 4);
      chk("pre_reset_busy", busy_o[0], 1);
      reset = 1'b1;
      line[0] = 1'b1;
      idle(1);
      reset = 1'b0;
      chk("post_reset_valid", valid_o[0], 0);
      chk("post_reset_busy", busy_o[0], 0);
      chk("post_reset_data", dout[0], 0);
      chk("post_reset_ovr", ovr_o[0], 0);
      ready = 1'b1;
      idle(10);
      send_frame(0, 8'h7E, 0, 0, -1, 0, k0);
      idle(4);
      chk("after_reset_data", last_data[0], 8'h7E);

      // Random frames on random receivers with a randomly toggling ready
      fork
         begin
            for (int n = 0; n < 16; n++) begin
               int d;
               d = $urandom_range(0, 2);
               send_frame(d, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                          -1, 0, k0);
               idle($urandom_range(4, 20));
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               ready = 1'($urandom_range(0, 1));
            end
         end
      join
      ready = 1'b1;
      idle(50);
      chk("queue_drained", expq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
